uart_flit_receiver: RTL and testbench
=====================================

# uart_flit_receiver

Receive end of the inter-device UART link. The block deserializes 8N1 bytes from `uart_rx`, assembles 16 consecutive bytes into one 128-bit `types::flit_t` and offers each flit to the receive path on a valid/ready handshake. It detects framing errors, inter-byte timeouts and output overruns, discarding the affected flit in each case. It is the counterpart of the flit transmitter that drives `uart_tx` on the far node.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: `cpuclk` cycles per UART bit; legal range ≥ 4.
- `TIMEOUT_BITS`, default 32: maximum idle gap between bytes of one flit, in bit times.

Ports:
- `cpuclk`  in  1  sole clock.
- `rst`  in  1  synchronous reset, active-high.
- `uart_rx`  in  1  serial line; asynchronous to `cpuclk`; idles high.
- `flit_out`  out  128 (`types::flit_t`)  assembled flit.
- `flit_out_valid`  out  1  `flit_out` holds a complete flit.
- `flit_out_ready`  in  1  downstream accepts the flit.
- `frame_err`  out  1  one-cycle pulse: the stop bit sampled low.
- `timeout_err`  out  1  one-cycle pulse: a partial flit was abandoned.
- `overrun_err`  out  1  one-cycle pulse: a completed flit was dropped.

## Operation
- `uart_rx` passes through a 2-FF synchronizer; the synchronizer flops reset to 1.
- Bit-level FSM:
  - IDLE: a synchronized falling edge loads `CLKS_PER_BIT/2 - 1` into the bit counter → START.
  - START: when the count expires, sample the line. Low → DATA. High → false start, back to IDLE with no error.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first → STOP.
  - STOP: sample once. High → byte valid, go to IDLE. Low → `frame_err`, go to BREAK.
  - BREAK: wait until the line is high → IDLE.
- Flit assembly:
  - Byte index 0..15. Byte 0 lands in `flit[127:120]` (header first); byte 15 lands in `flit[7:0]`.
  - A valid byte with index 15 completes the flit, and the index wraps to 0.
- Error handling, each with its discard rule:
  - Framing error: discard the partial flit and reset the index to 0.
  - Timeout: with index ≠ 0, a gap of more than `TIMEOUT_BITS × CLKS_PER_BIT` cycles between the end of a stop bit and the next start edge pulses `timeout_err` and resets the index. With index = 0 no timer runs.
  - Overrun: when a flit completes while `flit_out_valid && !flit_out_ready`, the new flit is dropped, `overrun_err` pulses, and the held flit is unchanged.
- Output register holds one flit. It loads on completion if it is empty or being accepted in the same cycle, which also covers the case where completion and the handshake coincide.

## Timing
- Reset values:
  - `flit_out_valid = 0`, `flit_out = 0`, all error pulses = 0.
  - FSM in IDLE, index = 0, timeout timer cleared.
- Synchronizer latency is 2 cycles. Each data bit is sampled at its nominal centre ± 1 cycle.
- `flit_out_valid` rises on the cycle after the stop-bit sample of byte 15.
- `flit_out_valid` stays high, and `flit_out` stays stable, until a cycle with `flit_out_ready = 1`. `flit_out_valid` falls on the next edge unless a new flit loads in that same cycle.
- `flit_out_ready` has no effect while `flit_out_valid = 0`.
- Reset asserted mid-byte or mid-flit abandons everything, with no error pulse. The next byte is recognized only after the line has been seen high and then falls.
- Error pulses are exactly 1 cycle wide and mutually exclusive per cycle. A frame error on byte 15 produces no flit and no overrun.

## Structure
- `types` package additions:
  - `FLIT_BYTES = 16`.
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP, BREAK).
  - Reuses the existing `flit_t`.
- Sub-module `uart_byte_rx`: synchronizer, bit FSM and bit counter. Outputs are `byte_data[7:0]`, `byte_valid` (1-cycle pulse) and `byte_frame_err`.
- The top level holds the byte index, shift register, timeout timer and output register.

## Test plan
All scenarios use `CLKS_PER_BIT = 16` and `TIMEOUT_BITS = 4`.
- Send bytes 0x00..0x0F back-to-back with `flit_out_ready = 1` → one flit 0x000102…0E0F. Valid goes high 1 cycle after the final stop sample and stays for 1 cycle.
- Send two flits with `flit_out_ready = 0`, then raise ready → the first flit is held, `overrun_err` pulses once at the second completion, and only the first flit is delivered.
- Send 5 bytes, then hold the line high for 80 cycles → `timeout_err` pulses once. The next 16 bytes 0xA0..0xAF yield flit 0xA0A1…AF.
- Give byte 3 a low stop bit and hold the line low for 40 cycles → `frame_err` pulses, no valid output, and recovery after the line goes high. The following 16 bytes assemble correctly.
- Apply an 8-cycle low glitch on an idle line → no byte, no error. Then assert `rst` at byte 9 of a flit → all outputs are 0, and a subsequent clean flit is received intact.
- Hold `flit_out_ready` high exactly in the completion cycle of the next flit → the old flit is accepted, the new flit loads with valid continuously high, and no overrun occurs.

Source files
------------

// File: rtl/uart_flit_receiver_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// types : flit type, flit size and UART receiver state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package types;

  localparam int FLIT_BYTES = 16;

  typedef logic [127:0] flit_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_flit_receiver_byte_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_byte_rx : 8N1 byte deserializer with input synchronizer
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_byte_rx
  import types::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  logic [1:0]     sync;
  logic           rx_prev;
  logic [1:0]     settle;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  uart_rx_state_t state;
  logic           rx_s;

  assign rx_s = sync[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync           <= 2'b11;
      rx_prev        <= 1'b1;
      settle         <= 2'd0;
      cnt            <= '0;
      bit_idx        <= 3'd0;
      state          <= IDLE;
      byte_data      <= 8'd0;
      byte_valid     <= 1'b0;
      byte_frame_err <= 1'b0;
    end else begin
      sync           <= {sync[0], rx};
      rx_prev        <= rx_s;
      byte_valid     <= 1'b0;
      byte_frame_err <= 1'b0;
      // Edges are ignored until the synchronizer holds real line samples, so a
      // line held low through reset is not mistaken for a start bit.
      if (settle != 2'd3) settle <= settle + 2'd1;

      case (state)
        IDLE: begin
          if (settle == 2'd3 && rx_prev && !rx_s) begin
            cnt   <= HALF_CNT;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!rx_s) begin
            cnt     <= FULL_CNT;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            byte_data <= {rx_s, byte_data[7:1]};
            cnt       <= FULL_CNT;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_s) begin
            byte_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            byte_frame_err <= 1'b1;
            state          <= BREAK;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_flit_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_flit_receiver : assembles 16 UART bytes into a flit, valid/ready output
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_flit_receiver
  import types::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic  cpuclk,
  input  logic  rst,
  input  logic  uart_rx,
  output flit_t flit_out,
  output logic  flit_out_valid,
  input  logic  flit_out_ready,
  output logic  frame_err,
  output logic  timeout_err,
  output logic  overrun_err
);

  // The idle timer starts at the stop-bit centre, half a bit before its end.
  localparam int TIMEOUT_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT + CLKS_PER_BIT / 2;
  localparam int TW            = $clog2(TIMEOUT_LIMIT + 1);

  logic [7:0]   byte_data;
  logic         byte_valid;
  logic         rx_busy;
  logic [3:0]   idx;
  logic [119:0] shift;
  logic [TW-1:0] timer;
  logic         idx_last;

  assign idx_last = (idx == 4'(FLIT_BYTES - 1));

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk           (cpuclk),
    .rst           (rst),
    .rx            (uart_rx),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .byte_frame_err(frame_err),
    .busy          (rx_busy)
  );

  always_ff @(posedge cpuclk) begin
    if (rst) begin
      idx            <= 4'd0;
      shift          <= '0;
      timer          <= '0;
      flit_out       <= '0;
      flit_out_valid <= 1'b0;
      timeout_err    <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      if (flit_out_valid && flit_out_ready) flit_out_valid <= 1'b0;

      if (byte_valid) begin
        timer <= '0;
        if (idx_last) begin
          idx <= 4'd0;
          if (!flit_out_valid || flit_out_ready) begin
            flit_out       <= {shift, byte_data};
            flit_out_valid <= 1'b1;
          end else begin
            overrun_err <= 1'b1;
          end
        end else begin
          idx   <= idx + 4'd1;
          shift <= {shift[111:0], byte_data};
        end
      end else if (frame_err) begin
        idx   <= 4'd0;
        timer <= '0;
      end else if (idx == 4'd0 || rx_busy) begin
        timer <= '0;
      end else if (timer == TW'(TIMEOUT_LIMIT)) begin
        timeout_err <= 1'b1;
        idx         <= 4'd0;
        timer       <= '0;
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_flit_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_flit_receiver : directed bench, CLKS_PER_BIT=16, TIMEOUT_BITS=4
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_flit_receiver;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         uart_rx = 1'b1;
  logic         flit_out_ready = 1'b0;
  logic [127:0] flit_out;
  logic         flit_out_valid, frame_err, timeout_err, overrun_err;

  always #5 clk = ~clk;

  uart_flit_receiver #(.CLKS_PER_BIT(16), .TIMEOUT_BITS(4)) dut (
    .cpuclk        (clk),
    .rst           (rst),
    .uart_rx       (uart_rx),
    .flit_out      (flit_out),
    .flit_out_valid(flit_out_valid),
    .flit_out_ready(flit_out_ready),
    .frame_err     (frame_err),
    .timeout_err   (timeout_err),
    .overrun_err   (overrun_err)
  );

  typedef struct {
    logic [7:0]   base;
    logic [7:0]   step;
    logic [127:0] exp;
  } vec_t;

  int n_checks = 0, n_err = 0;
  int n_vhi = 0, n_vlo = 0, n_fe = 0, n_te = 0, n_oe = 0, n_multi = 0, n_hold = 0;
  logic [127:0] got[$];
  logic         p_valid = 1'b0, p_ready = 1'b0;
  logic [127:0] p_flit = '0;

  // Observes outputs mid-cycle; inputs only change 2 ns after a rising edge.
  always @(negedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
    end else begin
      if (flit_out_valid) n_vhi <= n_vhi + 1; else n_vlo <= n_vlo + 1;
      if (frame_err)   n_fe <= n_fe + 1;
      if (timeout_err) n_te <= n_te + 1;
      if (overrun_err) n_oe <= n_oe + 1;
      if (int'(frame_err) + int'(timeout_err) + int'(overrun_err) > 1) n_multi <= n_multi + 1;
      if (flit_out_valid && flit_out_ready) got.push_back(flit_out);
      if (p_valid && !p_ready && (!flit_out_valid || flit_out != p_flit)) n_hold <= n_hold + 1;
      p_valid <= flit_out_valid;
      p_ready <= flit_out_ready;
      p_flit  <= flit_out;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2 uart_rx = f[k];
      repeat (15) @(posedge clk);
    end
  endtask

  task automatic send_flit(input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b;
    b = base;
    for (int i = 0; i < 16; i++) begin
      send_byte(b, 1'b1);
      b = b + step;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #2 flit_out_ready = r;
  endtask

  function automatic logic [127:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 128'hX;
  endfunction

  vec_t vecs[5];
  int g0, fe0, te0, oe0, vlo0;

  initial begin
    vecs[0] = '{8'h00, 8'h01, 128'h000102030405060708090A0B0C0D0E0F};
    vecs[1] = '{8'hF0, 8'h01, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF};
    vecs[2] = '{8'h5A, 8'h00, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A};
    vecs[3] = '{8'h01, 8'h11, 128'h0112233445566778899AABBCCDDEEF00};
    vecs[4] = '{8'hFF, 8'hFF, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0};

    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset flit_out", flit_out, '0);
    chk("reset valid", 128'(flit_out_valid), 0);
    chk("reset errors", 128'({frame_err, timeout_err, overrun_err}), 0);
    idle(10);

    // Back-to-back flits, ready held high: valid lasts one cycle per flit.
    set_ready(1'b1);
    for (int v = 0; v < 5; v++) begin
      g0 = got.size(); fe0 = n_fe; te0 = n_te; oe0 = n_oe;
      begin : row
        int vh0;
        vh0 = n_vhi;
        send_flit(vecs[v].base, vecs[v].step);
        idle(10);
        chk($sformatf("vec%0d flits", v), 128'(got.size() - g0), 1);
        chk($sformatf("vec%0d data", v), got_at(g0), vecs[v].exp);
        chk($sformatf("vec%0d valid cycles", v), 128'(n_vhi - vh0), 1);
      end
      chk($sformatf("vec%0d errors", v), 128'((n_fe - fe0) + (n_te - te0) + (n_oe - oe0)), 0);
    end

    // Overrun: second flit dropped, first held until ready.
    set_ready(1'b0);
    g0 = got.size(); oe0 = n_oe;
    send_flit(8'h10, 8'h01);
    idle(10);
    send_flit(8'h20, 8'h01);
    idle(10);
    chk("ovr overrun pulses", 128'(n_oe - oe0), 1);
    chk("ovr valid held", 128'(flit_out_valid), 1);
    chk("ovr held flit", flit_out, 128'h101112131415161718191A1B1C1D1E1F);
    chk("ovr nothing delivered", 128'(got.size() - g0), 0);
    set_ready(1'b1);
    idle(3);
    chk("ovr delivered count", 128'(got.size() - g0), 1);
    chk("ovr delivered flit", got_at(g0), 128'h101112131415161718191A1B1C1D1E1F);
    chk("ovr valid dropped", 128'(flit_out_valid), 0);

    // Timeout after a partial flit of 5 bytes.
    g0 = got.size(); te0 = n_te;
    for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i), 1'b1);
    idle(80);
    chk("tmo pulses", 128'(n_te - te0), 1);
    chk("tmo no flit", 128'(got.size() - g0), 0);
    send_flit(8'hA0, 8'h01);
    idle(10);
    chk("tmo next flit", got_at(g0), 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    chk("tmo no extra pulse", 128'(n_te - te0), 1);

    // Framing error on byte 3 with the line held low.
    g0 = got.size(); fe0 = n_fe; te0 = n_te;
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1'b1);
    send_byte(8'h33, 1'b0);
    idle(24);
    #2 uart_rx = 1'b1;
    idle(32);
    chk("frm pulses", 128'(n_fe - fe0), 1);
    chk("frm no flit", 128'(got.size() - g0), 0);
    send_flit(8'hB0, 8'h01);
    idle(10);
    chk("frm next flit", got_at(g0), 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
    chk("frm no timeout", 128'(n_te - te0), 0);

    // Short glitch, then reset in the middle of byte 9 with the line low.
    g0 = got.size(); fe0 = n_fe; te0 = n_te; oe0 = n_oe;
    @(posedge clk); #2 uart_rx = 1'b0;
    idle(8);
    #2 uart_rx = 1'b1;
    idle(60);
    chk("glitch no flit/error", 128'((got.size() - g0) + (n_fe - fe0) + (n_te - te0) + (n_oe - oe0)), 0);
    for (int i = 0; i < 9; i++) send_byte(8'hC0 + 8'(i), 1'b1);
    @(posedge clk); #2 uart_rx = 1'b0;
    idle(20);
    #2 rst = 1'b1;
    idle(3);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst flit_out", flit_out, '0);
    chk("rst outputs", 128'({flit_out_valid, frame_err, timeout_err, overrun_err}), 0);
    idle(20);
    #2 uart_rx = 1'b1;
    idle(40);
    chk("rst no flit/error", 128'((got.size() - g0) + (n_fe - fe0) + (n_te - te0) + (n_oe - oe0)), 0);
    send_flit(8'hD0, 8'h01);
    idle(10);
    chk("rst next flit", got_at(g0), 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF);

    // Ready asserted only in the completion cycle of the next flit.
    set_ready(1'b0);
    g0 = got.size(); oe0 = n_oe;
    send_flit(8'hE0, 8'h01);
    idle(10);
    vlo0 = n_vlo;
    for (int i = 0; i < 15; i++) send_byte(8'h60 + 8'(i), 1'b1);
    fork
      send_byte(8'h6F, 1'b1);
      begin
        // Stop-bit sample lands 155 edges after the start bit is driven
        // (3-cycle edge detect, half bit, 9 full bits); completion follows.
        repeat (156) @(posedge clk);
        #2 flit_out_ready = 1'b1;
        @(posedge clk);
        #2 flit_out_ready = 1'b0;
      end
    join
    idle(5);
    chk("coin delivered old", got_at(g0), 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF);
    chk("coin delivered count", 128'(got.size() - g0), 1);
    chk("coin new flit", flit_out, 128'h606162636465666768696A6B6C6D6E6F);
    chk("coin valid never low", 128'(n_vlo - vlo0), 0);
    chk("coin no overrun", 128'(n_oe - oe0), 0);
    set_ready(1'b1);
    idle(3);
    chk("coin new delivered", got_at(g0 + 1), 128'h606162636465666768696A6B6C6D6E6F);

    chk("errors exclusive", 128'(n_multi), 0);
    chk("held flit stable", 128'(n_hold), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
